// File: rtl/control_skid_buffer_if.sv
// Handshake bundle between the instruction decoder (upstream), the skid
// buffer and the downstream control interface.
interface control_skid_buffer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_control;
    logic [CNT_W-1:0] stall_count;

    // The buffer itself.
    modport slave (
        input  flush,
        input  in_valid,
        output in_ready,
        input  in_control,
        output out_valid,
        input  out_ready,
        output out_control,
        output stall_count
    );

    // The environment: decoder on one side, control consumer on the other.
    modport master (
        output flush,
        output in_valid,
        input  in_ready,
        output in_control,
        input  out_valid,
        output out_ready,
        input  out_control,
        input  stall_count
    );
endinterface

// File: rtl/control_skid_buffer.sv
// Two-entry skid buffer for decoded control words. The main register drives
// out_control directly; the skid register catches the one word that can be
// accepted while the consumer stalls. in_ready depends only on the state
// register and flush, so there is no combinational path from out_ready.
module control_skid_buffer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    control_skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] skid_r;
    logic [CNT_W-1:0] stall_r;

    logic in_fire_s;
    logic out_fire_s;
    logic load_main_in_s;
    logic load_main_skid_s;
    logic load_skid_s;

    assign bus.in_ready    = (state_r != FULL) & ~bus.flush;
    assign bus.out_valid   = (state_r == BUSY) | (state_r == FULL);
    assign bus.out_control = main_r;
    assign bus.stall_count = stall_r;

    assign in_fire_s  = bus.in_valid & bus.in_ready;
    assign out_fire_s = bus.out_valid & bus.out_ready;

    // Next-state and register-load decode; flush overrides every transition.
    always_comb begin
        state_s          = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (bus.flush) begin
            state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) begin
                        load_main_in_s = 1'b1;
                        state_s        = BUSY;
                    end else begin
                        state_s = EMPTY;
                    end
                end
                BUSY: begin
                    if (in_fire_s && !out_fire_s) begin
                        load_skid_s = 1'b1;
                        state_s     = FULL;
                    end else if (in_fire_s && out_fire_s) begin
                        load_main_in_s = 1'b1;
                        state_s        = BUSY;
                    end else if (out_fire_s) begin
                        state_s = EMPTY;
                    end else begin
                        state_s = BUSY;
                    end
                end
                FULL: begin
                    if (out_fire_s) begin
                        load_main_skid_s = 1'b1;
                        state_s          = BUSY;
                    end else begin
                        state_s = FULL;
                    end
                end
                default: begin
                    state_s = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Main register: new word from upstream or promotion from skid; otherwise
    // it keeps its value, including while EMPTY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= {WIDTH{1'b0}};
        end else if (load_main_in_s) begin
            main_r <= bus.in_control;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid register: captures the word accepted while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_r <= {WIDTH{1'b0}};
        end else if (load_skid_s) begin
            skid_r <= bus.in_control;
        end else begin
            skid_r <= skid_r;
        end
    end

    // Saturating count of cycles where a word waits on the consumer; flush
    // does not clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_r <= {CNT_W{1'b0}};
        end else if (bus.out_valid && !bus.out_ready && (stall_r != {CNT_W{1'b1}})) begin
            stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_r <= stall_r;
        end
    end

endmodule

// File: tb/tb_control_skid_buffer.sv
// Scoreboard bench for control_skid_buffer. The driver keeps a word-count
// model of the buffer (capacity two) and pushes every word it expects to be
// accepted into exp_q; the monitor on the falling edge compares the DUT
// against that model and pops words as they are consumed.
module tb_control_skid_buffer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    control_skid_buffer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    control_skid_buffer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int               n_cmp    = 0;
    int               n_fail   = 0;
    int               n_pop    = 0;
    int               cur_cnt  = 0;
    int               exp_stall = 0;
    logic [WIDTH-1:0] exp_last = '0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: compare handshake outputs with the model, score delivered words.
    always @(negedge clk) begin
        chk("in_ready", 64'(bus.in_ready), 64'(cur_cnt < 2 && !bus.flush));
        chk("out_valid", 64'(bus.out_valid), 64'(cur_cnt > 0));
        chk("stall_count", 64'(bus.stall_count), 64'(exp_stall));
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h required none", bus.out_control);
            end else begin
                chk("out_control", 64'(bus.out_control), 64'(exp_q[0]));
                exp_last = exp_q[0];
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    n_pop++;
                end
            end
        end else begin
            chk("out_control_idle", 64'(bus.out_control), 64'(exp_last));
        end
        if (bus.flush) exp_q.delete();
    end

    // One clock cycle of stimulus; the model advances right after the edge.
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] ic, input logic ordy,
                         input logic fl, output logic acc);
        bus.in_valid   = iv;
        bus.in_control = ic;
        bus.out_ready  = ordy;
        bus.flush      = fl;
        acc = iv && (cur_cnt < 2) && !fl && !rst;
        if (acc) exp_q.push_back(ic);
        @(posedge clk);
        #1;
        if (cur_cnt > 0 && !ordy && exp_stall < SAT) exp_stall++;
        if (fl) cur_cnt = 0;
        else cur_cnt = cur_cnt - ((cur_cnt > 0 && ordy) ? 1 : 0) + (acc ? 1 : 0);
    endtask

    // Offer a word until the model says it is taken.
    task automatic send(input logic [WIDTH-1:0] w, input logic ordy);
        logic acc;
        int   k;
        acc = 1'b0;
        k = 0;
        while (!acc && k < 50) begin
            cycle(1'b1, w, ordy, 1'b0, acc);
            k++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: word %0h not accepted within 50 cycles", w);
        end
    endtask

    // Consume everything still buffered.
    task automatic drain();
        logic acc;
        int   k;
        k = 0;
        while (cur_cnt > 0 && k < 10) begin
            cycle(1'b0, '0, 1'b1, 1'b0, acc);
            k++;
        end
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   p0;
        int   s0;

        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_control = '0;
        bus.out_ready  = 1'b0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, one-cycle latency.
        p0 = n_pop;
        cycle(1'b1, 32'h0000_0013, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("single_word_count", 64'(n_pop - p0), 64'd1);

        // 100-word back-to-back stream.
        p0 = n_pop;
        for (int i = 0; i < 100; i++) cycle(1'b1, 32'h0001_0000 + i, 1'b1, 1'b0, acc);
        drain();
        chk("stream_count", 64'(n_pop - p0), 64'd100);
        chk("stream_stall", 64'(bus.stall_count), 64'd0);

        // Consumer stalled: A1, A2 fill the buffer, A3 waits upstream.
        p0 = n_pop;
        send(32'hA1, 1'b0);
        send(32'hA2, 1'b0);
        repeat (3) cycle(1'b1, 32'hA3, 1'b0, 1'b0, acc);
        send(32'hA3, 1'b1);
        drain();
        chk("stall_order_count", 64'(n_pop - p0), 64'd3);

        // Flush while FULL with a word offered; consumer takes B1 that cycle.
        send(32'hB1, 1'b0);
        send(32'hB2, 1'b0);
        s0 = exp_stall;
        cycle(1'b1, 32'hB3, 1'b1, 1'b1, acc);
        cycle(1'b0, '0, 1'b1, 1'b0, acc);
        chk("flush_stall_kept", 64'(bus.stall_count), 64'(s0));
        chk("flush_empty", 64'(bus.out_valid), 64'd0);

        // Long stall saturates the counter.
        send(32'hC1, 1'b0);
        repeat (20) cycle(1'b0, '0, 1'b0, 1'b0, acc);
        chk("stall_saturated", 64'(bus.stall_count), 64'(SAT));
        drain();

        // Asynchronous reset in FULL, mid-cycle.
        send(32'hD1, 1'b0);
        send(32'hD2, 1'b0);
        #2;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        cur_cnt      = 0;
        exp_stall    = 0;
        exp_last     = '0;
        exp_q.delete();
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_out_control", 64'(bus.out_control), 64'd0);
        chk("async_rst_stall", 64'(bus.stall_count), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) != 0), $urandom, ($urandom_range(9) < 6),
                  ($urandom_range(19) == 0), acc);
        end
        drain();
        chk("final_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
